kpscan_ctrl: RTL and testbench

//  Active keypad scanner for the 4x4 matrix keypad. Drives column lines low one
//  at a time and samples the row lines. Debounces press and release, then emits
//  one key-event pulse carrying the 4-bit key code. Sits between the keypad pins
//  and the control-register logic that consumes key events.

---
 rtl/kpscan_pkg.sv | 25 ++
 rtl/kpscan_keymap.sv | 47 ++++
 rtl/kpscan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_kpscan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/kpscan_pkg.sv
// kpscan_pkg: shared types and constants for the 4x4 keypad scanner.
// Column/row codes are active-low, one zero bit per line.
package kpscan_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    typedef logic [3:0] key_t;

    localparam logic [3:0] COL0     = 4'b0111;
    localparam logic [3:0] COL1     = 4'b1011;
    localparam logic [3:0] COL2     = 4'b1101;
    localparam logic [3:0] COL3     = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'hF;

    // Bits needed to count 0..n-1, never below 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kpscan_keymap.sv
// kpscan_keymap: combinational (column, row) -> key code lookup.
// one_hot_ok drops when the row pattern is idle or has several keys down.
module kpscan_keymap
    import kpscan_pkg::*;
(
    input  logic [3:0] kpc,
    input  logic [3:0] row,
    output key_t       key_code,
    output logic       one_hot_ok
);

    logic [1:0] ci;
    logic [1:0] ri;

    always_comb begin
        ci = 2'd0;
        ri = 2'd0;
        one_hot_ok = 1'b1;
        unique case (kpc)
            COL0:    ci = 2'd0;
            COL1:    ci = 2'd1;
            COL2:    ci = 2'd2;
            COL3:    ci = 2'd3;
            default: ci = 2'd0;
        endcase
        unique case (row)
            4'b0111: ri = 2'd0;
            4'b1011: ri = 2'd1;
            4'b1101: ri = 2'd2;
            4'b1110: ri = 2'd3;
            default: one_hot_ok = 1'b0;
        endcase
    end

    // Digits 1..9 are row-major in the first three columns.
    always_comb begin
        key_code = 4'h0;
        unique case (1'b1)
            (ci == 2'd3):                key_code = 4'hA + {2'b00, ri};
            (ri == 2'd3 && ci == 2'd0):  key_code = 4'hE;
            (ri == 2'd3 && ci == 2'd1):  key_code = 4'h0;
            (ri == 2'd3 && ci == 2'd2):  key_code = 4'hF;
            default: key_code = 4'd1 + 4'd3 * {2'b00, ri} + {2'b00, ci};
        endcase
    end

endmodule

// File: rtl/kpscan_ctrl.sv
// kpscan_ctrl: 4x4 keypad scanner with press/release debounce and key events.
// Define KPSCAN_REPEAT_EN to add auto-repeat pulses while a key is held.
module kpscan_ctrl
    import kpscan_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic       key_valid,
    output key_t       key_code,
    output logic       key_held
);

    localparam int DIV_W = cnt_width(SCAN_DIV);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("kpscan_ctrl: parameter out of range");
    end

    state_t           state;
    state_t           state_n;
    logic [3:0]       kpr_m;
    logic [3:0]       kpr_s;
    logic [3:0]       row_q;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] cnt;

    logic dwell_end;
    logic row_hit;
    logic row_same;
    logic cnt_done;
    logic adv;
    logic capture;
    logic fire;
    logic rel_done;
    logic cnt_inc;
    logic rep_fire;
    key_t map_code;
    logic one_hot_ok;

    kpscan_keymap u_keymap (
        .kpc        (kpc),
        .row        (row_q),
        .key_code   (map_code),
        .one_hot_ok (one_hot_ok)
    );

    assign dwell_end = (div == DIV_LAST);
    assign row_hit   = (kpr_s != ROW_IDLE);
    assign row_same  = (kpr_s == row_q);
    assign cnt_done  = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= SCAN;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        adv      = 1'b0;
        capture  = 1'b0;
        fire     = 1'b0;
        rel_done = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state)
            SCAN: begin
                if (dwell_end) begin
                    if (row_hit) begin
                        capture = 1'b1;
                        state_n = DEBOUNCE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!row_same || !one_hot_ok) begin
                    adv     = 1'b1;
                    state_n = SCAN;
                end else if (cnt_done) begin
                    fire    = 1'b1;
                    state_n = PRESSED;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            PRESSED: begin
                if (!row_same) state_n = RELEASE;
            end
            RELEASE: begin
                // Any non-idle row restarts the release count.
                if (row_hit) begin
                    cnt_inc = 1'b0;
                end else if (cnt_done) begin
                    rel_done = 1'b1;
                    adv      = 1'b1;
                    state_n  = SCAN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kpr_m     <= ROW_IDLE;
            kpr_s     <= ROW_IDLE;
            row_q     <= ROW_IDLE;
            kpc       <= COL0;
            div       <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
        end else begin
            kpr_m <= kpr;
            kpr_s <= kpr_m;
            div   <= (state == SCAN && !dwell_end) ? div + DIV_W'(1) : '0;
            cnt   <= cnt_inc ? cnt + CNT_W'(1) : '0;
            if (capture) row_q <= kpr_s;
            if (adv)     kpc   <= {kpc[0], kpc[3:1]};
            key_valid <= fire | rep_fire;
            if (fire) begin
                key_code <= map_code;
                key_held <= 1'b1;
            end
            if (rel_done) key_held <= 1'b0;
        end
    end

`ifdef KPSCAN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                            : REPEAT_PERIOD;
    localparam int REP_W = cnt_width(REP_MAX);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
    logic             rep_hit;

    // First repeat waits the long delay, later ones the short period.
    assign rep_hit  = rep_first ? (rep_cnt == REP_W'(REPEAT_DELAY - 1))
                                : (rep_cnt == REP_W'(REPEAT_PERIOD - 1));
    assign rep_fire = (state == PRESSED) && (state_n == PRESSED) && rep_hit;

    always_ff @(posedge clk) begin
        if (reset || state != PRESSED) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_hit) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_kpscan_ctrl.sv
// tb_kpscan_ctrl: randomized scoreboard bench for kpscan_ctrl with a
// switch-matrix keypad model and a key-event monitor.
module tb_kpscan_ctrl;

    localparam int SD = 8;
    localparam int DB = 4;
    localparam int RD = 40;
    localparam int RP = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] mask = '0;
    logic        bounce = 1'b0;
    int          passes = 0;
    int          total = 0;
    int          cyc = 0;
    logic [3:0]  exp_q[$];
    int          pulse_t[$];
    logic [3:0]  keys[4][4];

    kpscan_ctrl #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .kpr       (kpr),
        .kpc       (kpc),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Switch matrix: a row reads low when a closed key sits on a driven column.
    always_comb begin
        kpr = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c] && !kpc[3-c]) kpr[3-r] = 1'b0;
        if (bounce) kpr = 4'hF;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset && key_valid) begin
            pulse_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: key_valid=1 code=%0h, required none",
                         key_code);
            end else begin
                check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic v, input int maxc, input string name);
        int k;
        k = 0;
        while (key_held !== v && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, key_held}, {31'd0, v});
    endtask

    function automatic logic [3:0] colc(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[3-c] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] bit_of(input int r, input int c);
        logic [15:0] m;
        m = '0;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev;
        int         k;
        int         r;
        int         c;
        int         r2;

        keys[0] = '{4'h1, 4'h2, 4'h3, 4'hA};
        keys[1] = '{4'h4, 4'h5, 4'h6, 4'hB};
        keys[2] = '{4'h7, 4'h8, 4'h9, 4'hC};
        keys[3] = '{4'hE, 4'h0, 4'hF, 4'hD};

        // Reset, then idle scan rotation.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("rst_kpc", {28'd0, kpc}, 32'h7);
                check("rst_valid", {31'd0, key_valid}, 32'd0);
                check("rst_code", {28'd0, key_code}, 32'd0);
                check("rst_held", {31'd0, key_held}, 32'd0);
            end
            check("scan_kpc", {28'd0, kpc}, {28'd0, colc((i / SD) % 4)});
        end

        // Single press on column 2, row 1.
        exp_q.push_back(keys[1][2]);
        mask = bit_of(1, 2);
        wait_held(1'b1, 100, "t2_held");
        tick(5);
        check("t2_kpc_frozen", {28'd0, kpc}, {28'd0, colc(2)});
        check("t2_held_stay", {31'd0, key_held}, 32'd1);
        check("t2_one_event", exp_q.size(), 32'd0);

        // Release with one bounce back to the pressed row.
        mask = '0;
        tick(4);
        mask = bit_of(1, 2);
        tick(1);
        mask = '0;
        tick(4);
        check("t4_held_bounce", {31'd0, key_held}, 32'd1);
        wait_held(1'b0, 20, "t4_released");
        check("t4_next_col", {28'd0, kpc}, {28'd0, colc(3)});

        // Press bounces open during debounce: no event, then a stable press.
        k = 0;
        prev = kpc;
        @(negedge clk);
        while (!(prev != colc(1) && kpc == colc(1)) && k < 100) begin
            prev = kpc;
            @(negedge clk);
            k++;
        end
        check("t3_col_found", {28'd0, kpc}, {28'd0, colc(1)});
        mask = bit_of(3, 1);
        tick(SD);
        bounce = 1'b1;
        tick(2);
        bounce = 1'b0;
        tick(2);
        check("t3_no_press", {31'd0, key_held}, 32'd0);
        exp_q.push_back(keys[3][1]);
        wait_held(1'b1, 100, "t3_stable_held");
        mask = '0;
        wait_held(1'b0, 50, "t3_released");

        // Reset while a key is held.
        exp_q.push_back(keys[2][0]);
        mask = bit_of(2, 0);
        wait_held(1'b1, 100, "t5_held");
        tick(3);
        reset = 1'b1;
        mask = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_kpc", {28'd0, kpc}, 32'h7);
        check("t5_held", {31'd0, key_held}, 32'd0);
        check("t5_code", {28'd0, key_code}, 32'd0);
        check("t5_valid", {31'd0, key_valid}, 32'd0);

        // Random single presses and same-column multi-key presses.
        for (int it = 0; it < 12; it++) begin
            c = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                r2 = (r + $urandom_range(1, 3)) % 4;
                mask = bit_of(r, c) | bit_of(r2, c);
                tick(100);
                check("rnd_multi_none", {31'd0, key_held}, 32'd0);
                mask = '0;
                tick(6);
            end else begin
                exp_q.push_back(keys[r][c]);
                mask = bit_of(r, c);
                wait_held(1'b1, 100, "rnd_press");
                tick($urandom_range(1, 20));
                mask = '0;
                wait_held(1'b0, 50, "rnd_release");
            end
        end

        // Long hold of key A.
        tick(3);
        pulse_t.delete();
        exp_q.push_back(keys[0][3]);
`ifdef KPSCAN_REPEAT_EN
        repeat (4) exp_q.push_back(keys[0][3]);
`endif
        mask = bit_of(0, 3);
        wait_held(1'b1, 100, "t6_held");
        tick(72);
        mask = '0;
        wait_held(1'b0, 50, "t6_released");
        tick(2);
`ifdef KPSCAN_REPEAT_EN
        check("t6_pulses", pulse_t.size(), 32'd5);
        if (pulse_t.size() == 5)
            for (int j = 1; j < 5; j++)
                check("t6_spacing", pulse_t[j] - pulse_t[0], RD + (j - 1) * RP);
`else
        check("t6_pulses", pulse_t.size(), 32'd1);
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
